// File: rtl/mirror_period_meter_pkg.sv
// Shared definitions for the mirror period meter: FSM encoding, default
// period limits and the deviation helper used by the lock tracker.
package mirror_period_meter_pkg;

    localparam int unsigned PERIOD_W          = 24;
    localparam int unsigned DEFAULT_PERIOD_C  = 50000;
    localparam int unsigned MIN_PERIOD_C      = 25000;
    localparam int unsigned MAX_PERIOD_C      = 100000;
    localparam int unsigned AVG_LOG2_C        = 3;
    localparam int unsigned TOL_SHIFT_C       = 4;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } meter_state_e;

    // Magnitude of a - b in 25 bits; cannot overflow for any 24-bit inputs.
    function automatic logic [PERIOD_W:0] abs_diff(input logic [PERIOD_W-1:0] a,
                                                   input logic [PERIOD_W-1:0] b);
        logic [PERIOD_W:0] diff;
        if (a >= b) begin
            diff = {1'b0, a} - {1'b0, b};
        end else begin
            diff = {1'b0, b} - {1'b0, a};
        end
        return diff;
    endfunction

endpackage

// File: rtl/mirror_period_meter_zc_edge_detect.sv
// Brings the asynchronous zero-crossing input into the clock domain and
// emits a registered one-cycle pulse per rising edge. Edges are suppressed
// until the synchronizer pipeline has refilled after reset, so a zc_i that is
// already high at release is not mistaken for a new crossing.
module zc_edge_detect (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic zc_i,
    output logic zc_edge_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic       edge_q;
    logic       edge_d;
    logic [1:0] fill_q;
    logic [1:0] fill_d;

    // Track pipeline fill after reset and form the rising-edge term.
    always_comb begin
        fill_d = fill_q;
        edge_d = 1'b0;
        if (fill_q != 2'd3) begin
            fill_d = fill_q + 2'd1;
        end else begin
            fill_d = fill_q;
        end
        if (fill_q == 2'd3) begin
            edge_d = sync2_q & ~prev_q;
        end else begin
            edge_d = 1'b0;
        end
    end

    // Two-flop synchronizer, previous-value register and registered edge pulse.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            fill_q  <= 2'd0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= zc_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= fill_d;
            edge_q  <= edge_d;
        end
    end

    assign zc_edge_o = edge_q;

endmodule

// File: rtl/mirror_period_meter.sv
// Measures the mirror rotation period from zero-crossing edges, averages
// blocks of 2^AVG_LOG2_P samples, tracks lock against a tolerance window and
// flags loss of the crossing signal with a timeout pulse.
module mirror_period_meter
    import mirror_period_meter_pkg::*;
#(
    parameter int unsigned DEFAULT_PERIOD_P = DEFAULT_PERIOD_C,
    parameter int unsigned MIN_PERIOD_P     = MIN_PERIOD_C,
    parameter int unsigned MAX_PERIOD_P     = MAX_PERIOD_C,
    parameter int unsigned AVG_LOG2_P       = AVG_LOG2_C,
    parameter int unsigned TOL_SHIFT_P      = TOL_SHIFT_C
) (
    input  logic                clk_i,
    input  logic                nrst_i,
    input  logic                zc_i,
    input  logic                hold_i,
    output logic [PERIOD_W-1:0] period_o,
    output logic                period_valid_o,
    output logic                period_update_o,
    output logic                timeout_o
);

    localparam int unsigned ACC_W  = PERIOD_W + AVG_LOG2_P;
    localparam int unsigned SCNT_W = AVG_LOG2_P + 1;

    localparam logic [PERIOD_W-1:0] DEF_C      = PERIOD_W'(DEFAULT_PERIOD_P);
    localparam logic [PERIOD_W-1:0] MIN_C      = PERIOD_W'(MIN_PERIOD_P);
    localparam logic [PERIOD_W-1:0] MAX_C      = PERIOD_W'(MAX_PERIOD_P);
    localparam logic [SCNT_W-1:0]   LAST_SMP_C = SCNT_W'((1 << AVG_LOG2_P) - 1);

    logic                zc_edge_s;

    meter_state_e        state_q,   state_d;
    logic [PERIOD_W-1:0] cnt_q,     cnt_d;
    logic [ACC_W-1:0]    acc_q,     acc_d;
    logic [SCNT_W-1:0]   smp_cnt_q, smp_cnt_d;
    logic [PERIOD_W-1:0] period_q,  period_d;
    logic                valid_q,   valid_d;
    logic                update_q,  update_d;
    logic                timeout_q, timeout_d;

    logic [PERIOD_W-1:0] sample_s;
    logic                glitch_s;
    logic                timeout_hit_s;
    logic [ACC_W-1:0]    acc_sum_s;
    logic                block_done_s;
    logic [PERIOD_W-1:0] block_avg_s;
    logic [PERIOD_W:0]   dev_s;
    logic [PERIOD_W:0]   tol_s;
    logic                out_of_tol_s;

    zc_edge_detect u_zc_edge (
        .clk_i     (clk_i),
        .nrst_i    (nrst_i),
        .zc_i      (zc_i),
        .zc_edge_o (zc_edge_s)
    );

    // Per-edge sample, glitch and tolerance terms, plus timeout detection.
    // Timeout fires when the count is about to reach the maximum period, so
    // an edge arriving on that same cycle is pre-empted.
    always_comb begin
        sample_s      = cnt_q + 24'd1;
        glitch_s      = (sample_s < MIN_C);
        timeout_hit_s = (state_q != ST_SEARCH) && (cnt_q >= (MAX_C - 24'd1));
        acc_sum_s     = acc_q + ACC_W'(sample_s);
        block_done_s  = (smp_cnt_q == LAST_SMP_C);
        block_avg_s   = PERIOD_W'(acc_sum_s >> AVG_LOG2_P);
        dev_s         = abs_diff(sample_s, period_q);
        tol_s         = {1'b0, period_q >> TOL_SHIFT_P};
        out_of_tol_s  = (dev_s > tol_s);
    end

    // Next-state logic for the search/measure/lock FSM and its datapath.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        smp_cnt_d = smp_cnt_q;
        period_d  = period_q;
        valid_d   = valid_q;
        update_d  = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                cnt_d     = '0;
                acc_d     = '0;
                smp_cnt_d = '0;
                valid_d   = 1'b0;
                if (zc_edge_s) begin
                    state_d = ST_MEASURE;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_MEASURE, ST_LOCKED: begin
                if (timeout_hit_s) begin
                    timeout_d = 1'b1;
                    state_d   = ST_SEARCH;
                    cnt_d     = '0;
                    acc_d     = '0;
                    smp_cnt_d = '0;
                    valid_d   = 1'b0;
                end else if (zc_edge_s && !glitch_s) begin
                    cnt_d = '0;
                    if ((state_q == ST_LOCKED) && out_of_tol_s) begin
                        // Lost lock: this sample seeds the next block.
                        state_d   = ST_MEASURE;
                        acc_d     = ACC_W'(sample_s);
                        smp_cnt_d = SCNT_W'(1);
                        valid_d   = 1'b0;
                    end else if (block_done_s) begin
                        state_d   = ST_LOCKED;
                        acc_d     = '0;
                        smp_cnt_d = '0;
                        valid_d   = 1'b1;
                        if (!hold_i) begin
                            period_d = block_avg_s;
                            update_d = 1'b1;
                        end else begin
                            period_d = period_q;
                            update_d = 1'b0;
                        end
                    end else begin
                        acc_d     = acc_sum_s;
                        smp_cnt_d = smp_cnt_q + SCNT_W'(1);
                    end
                end else begin
                    if (cnt_q >= MAX_C) begin
                        cnt_d = MAX_C;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_SEARCH;
                cnt_d     = '0;
                acc_d     = '0;
                smp_cnt_d = '0;
                valid_d   = 1'b0;
            end
        endcase
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q   <= ST_SEARCH;
            cnt_q     <= '0;
            acc_q     <= '0;
            smp_cnt_q <= '0;
            period_q  <= DEF_C;
            valid_q   <= 1'b0;
            update_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            smp_cnt_q <= smp_cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            update_q  <= update_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_o        = period_q;
    assign period_valid_o  = valid_q;
    assign period_update_o = update_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_mirror_period_meter.sv
// Directed plus randomized bench for mirror_period_meter. Two instances share
// the clock: A uses a 1/16 tolerance window, B a 1/4 window for the hold test.
module tb_mirror_period_meter;

    localparam int DEF  = 100;
    localparam int MINP = 20;
    localparam int MAXP = 200;
    localparam int AVG  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst   = 1'b0;
    logic        zc_r   = 1'b0;
    logic        hold_r = 1'b0;
    logic        sel_r  = 1'b0;
    logic        zc_a, zc_b, hold_a, hold_b;
    logic [23:0] per_a, per_b, per_s;
    logic        val_a, val_b, upd_a, upd_b, to_a, to_b;
    logic        val_s, upd_s, to_s;

    assign zc_a   = (sel_r == 1'b0) ? zc_r   : 1'b0;
    assign zc_b   = (sel_r == 1'b1) ? zc_r   : 1'b0;
    assign hold_a = (sel_r == 1'b0) ? hold_r : 1'b0;
    assign hold_b = (sel_r == 1'b1) ? hold_r : 1'b0;
    assign per_s  = sel_r ? per_b : per_a;
    assign val_s  = sel_r ? val_b : val_a;
    assign upd_s  = sel_r ? upd_b : upd_a;
    assign to_s   = sel_r ? to_b  : to_a;

    mirror_period_meter #(.DEFAULT_PERIOD_P(100), .MIN_PERIOD_P(20), .MAX_PERIOD_P(200),
                          .AVG_LOG2_P(2), .TOL_SHIFT_P(4)) dut_a (
        .clk_i(clk), .nrst_i(nrst), .zc_i(zc_a), .hold_i(hold_a),
        .period_o(per_a), .period_valid_o(val_a), .period_update_o(upd_a), .timeout_o(to_a));

    mirror_period_meter #(.DEFAULT_PERIOD_P(100), .MIN_PERIOD_P(20), .MAX_PERIOD_P(200),
                          .AVG_LOG2_P(2), .TOL_SHIFT_P(2)) dut_b (
        .clk_i(clk), .nrst_i(nrst), .zc_i(zc_b), .hold_i(hold_b),
        .period_o(per_b), .period_valid_o(val_b), .period_update_o(upd_b), .timeout_o(to_b));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 = searching, 1 = measuring, 2 = locked.
    int   m_state;
    int   m_since;
    int   m_period;
    int   m_tol;
    bit   m_upd;
    int   m_smp[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_state  = 0;
        m_since  = 0;
        m_period = DEF;
        m_upd    = 1'b0;
        m_smp.delete();
    endtask

    // Apply one zero-crossing that arrives 'gap' cycles after the previous one.
    task automatic model_pulse(input int gap);
        int sample;
        int dev;
        int sum;
        m_upd = 1'b0;
        if (m_state == 0) begin
            m_state = 1;
            m_since = 0;
            m_smp.delete();
        end else begin
            m_since += gap;
            sample = m_since;
            if (sample >= MINP) begin
                m_since = 0;
                dev = sample - m_period;
                if (dev < 0) dev = -dev;
                if (m_state == 2 && dev > (m_period >> m_tol)) begin
                    m_state = 1;
                    m_smp.delete();
                    m_smp.push_back(sample);
                end else begin
                    m_smp.push_back(sample);
                    if (m_smp.size() == (1 << AVG)) begin
                        sum = 0;
                        foreach (m_smp[i]) sum += m_smp[i];
                        m_state = 2;
                        if (hold_r == 1'b0) begin
                            m_period = sum / (1 << AVG);
                            m_upd    = 1'b1;
                        end
                        m_smp.delete();
                    end
                end
            end
        end
    endtask

    // Raise zc, wait for the synchronized edge to be consumed, then compare.
    task automatic do_pulse(input string tag, input int gap);
        @(negedge clk);
        zc_r = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        model_pulse(gap);
        check({tag, " period"},  32'(per_s), 32'(m_period));
        check({tag, " valid"},   32'(val_s), (m_state == 2) ? 32'd1 : 32'd0);
        check({tag, " update"},  32'(upd_s), 32'(m_upd));
        check({tag, " timeout"}, 32'(to_s),  32'd0);
    endtask

    task automatic pulse_after(input string tag, input int gap);
        @(negedge clk);
        zc_r = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " update one-shot"}, 32'(upd_s), 32'd0);
        repeat (gap - 5) @(posedge clk);
        do_pulse(tag, gap);
    endtask

    initial begin
        int g;
        int to_cnt;
        int to_first;
        int flags;

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        #1;
        check("reset async period", 32'(per_a), 32'd100);
        @(negedge clk);
        nrst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("reset period A", 32'(per_a), 32'd100);
        check("reset period B", 32'(per_b), 32'd100);
        check("reset valid",    32'(val_a), 32'd0);
        check("reset update",   32'(upd_a), 32'd0);
        check("reset timeout",  32'(to_a),  32'd0);

        // Instance B: lock, then a held block, then a loaded block.
        sel_r = 1'b1;
        m_reset();
        m_tol = 2;
        do_pulse("B lock", 0);
        repeat (4) pulse_after("B lock", 100);
        hold_r = 1'b1;
        repeat (4) pulse_after("B held", 120);
        hold_r = 1'b0;
        repeat (4) pulse_after("B released", 120);
        check("B final period", 32'(per_b), 32'd120);

        // Instance A: initial lock at 100.
        @(negedge clk);
        zc_r  = 1'b0;
        sel_r = 1'b0;
        m_reset();
        m_tol = 4;
        do_pulse("A lock", 0);
        repeat (4) pulse_after("A lock", 100);
        check("A locked at 100", 32'(per_a), 32'd100);

        // Block 100,100,104,104 averages to 102; then 110 breaks lock.
        pulse_after("A blk", 100);
        pulse_after("A blk", 100);
        pulse_after("A blk", 104);
        pulse_after("A blk", 104);
        check("A avg 102", 32'(per_a), 32'd102);
        pulse_after("A out-of-tol", 110);
        check("A unlock period held", 32'(per_a), 32'd102);
        check("A unlock valid", 32'(val_a), 32'd0);

        // Relock, then a glitch edge 10 cycles after an accepted edge.
        repeat (3) pulse_after("A relock", 100);
        pulse_after("A glitch", 10);
        pulse_after("A after glitch", 90);
        check("A lock kept", 32'(val_a), 32'd1);

        // Randomized spacing, with occasional glitch edges.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 7) == 0) g = 10;
            else g = int'($urandom_range(90, 110));
            pulse_after("A rand", g);
        end
        for (int i = 0; i < 8 && m_state != 2; i++) begin
            pulse_after("A settle", m_period);
        end
        check("A locked before timeout", 32'(val_a), 32'd1);

        // Stop the crossings and watch for exactly one timeout pulse.
        @(negedge clk);
        zc_r = 1'b0;
        to_cnt = 0;
        to_first = 0;
        for (int i = 1; i <= 250; i++) begin
            @(posedge clk);
            #1;
            if (to_s === 1'b1) begin
                to_cnt++;
                if (to_first == 0) to_first = i;
            end
        end
        check("timeout count", 32'(to_cnt), 32'd1);
        check("timeout delay", 32'(to_first), 32'd200);
        check("timeout valid", 32'(val_a), 32'd0);
        check("timeout period held", 32'(per_a), 32'(m_period));
        m_state = 0;
        m_smp.delete();
        m_since = 0;

        // Reset mid-measure with zc held high through release.
        do_pulse("R mid", 0);
        pulse_after("R mid", 100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check("mid reset period", 32'(per_a), 32'd100);
        check("mid reset valid",  32'(val_a), 32'd0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        m_reset();
        flags = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (val_s !== 1'b0 || upd_s !== 1'b0 || to_s !== 1'b0 || per_s !== 24'd100) flags++;
        end
        check("post-release quiet", 32'(flags), 32'd0);
        @(negedge clk);
        zc_r = 1'b0;
        repeat (40) @(posedge clk);
        do_pulse("R relock", 0);
        repeat (4) pulse_after("R relock", 100);
        check("R relock valid", 32'(val_a), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
